seven_segment_mux: RTL

Parametrised, time-multiplexed seven-segment display driver for the board's common-anode LED banks. It scans `DIGITS` hexadecimal digits with a programmable refresh prescaler and blanks the anodes for a short interval at every digit change to suppress ghosting. Display contents are double-buffered so that updates take effect only at frame boundaries and never tear. It sits between the datapath (program counter, registers) and the board display pins.

---
 rtl/seven_segment_mux.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/seven_segment_mux.sv
`default_nettype none
// ============================================================================
// Module  : seven_segment_mux
// Purpose : Time-multiplexed, double-buffered hex driver for common-anode
//           seven-segment banks with anode guard blanking between digits.
//           Optional macro SSEG_ZERO_BLANK_EN enables leading-zero suppression.
// Revision: 1.0 - initial release
// ============================================================================
module seven_segment_mux #(
  parameter int DIGITS     = 4,
  parameter int DIV_WIDTH  = 16,
  parameter int GUARD      = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  output logic                  a,
  output logic                  b,
  output logic                  c,
  output logic                  d,
  output logic                  e,
  output logic                  f,
  output logic                  g,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int                   c_IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_IDX_W-1:0]   c_LAST_IDX = c_IDX_W'(DIGITS - 1);
  localparam logic [DIV_WIDTH-1:0] c_GUARD    = DIV_WIDTH'(GUARD);
  localparam logic                 c_INV      = (ACTIVE_LOW != 0);

  logic [DIV_WIDTH-1:0] r_pre;
  logic [c_IDX_W-1:0]   r_idx;
  logic                 r_pending;
  logic [4*DIGITS-1:0]  r_sh_data;
  logic [DIGITS-1:0]    r_sh_dp;
  logic [DIGITS-1:0]    r_sh_blank;
  logic [4*DIGITS-1:0]  r_dsp_data;
  logic [DIGITS-1:0]    r_dsp_dp;
  logic [DIGITS-1:0]    r_dsp_blank;
  logic [6:0]           r_seg;
  logic                 r_dp;
  logic [DIGITS-1:0]    r_an;
  logic                 r_frame_done;

  logic                 w_tick;
  logic                 w_bound;
  logic [3:0]           w_nib;
  logic                 w_sel_dp;
  logic                 w_sel_blank;
  logic                 w_sel_sup;
  logic [DIGITS-1:0]    w_onehot;
  logic [DIGITS-1:0]    w_sup;
  logic [6:0]           w_seg_lit;
  logic                 w_an_on;
  logic                 w_seg_on;
  logic                 w_dp_on;

  assign w_tick  = &r_pre;
  assign w_bound = w_tick && (r_idx == c_LAST_IDX);

`ifdef SSEG_ZERO_BLANK_EN
  // A digit is suppressed when it and every more-significant nibble are zero.
  assign w_sup[0] = 1'b0;
  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_zero_sup
    assign w_sup[gi] = (r_dsp_data[4*DIGITS-1:4*gi] == '0);
  end
`else
  assign w_sup = '0;
`endif

  always_comb begin
    w_nib       = 4'h0;
    w_sel_dp    = 1'b0;
    w_sel_blank = 1'b0;
    w_sel_sup   = 1'b0;
    w_onehot    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == c_IDX_W'(i)) begin
        w_nib       = r_dsp_data[4*i +: 4];
        w_sel_dp    = r_dsp_dp[i];
        w_sel_blank = r_dsp_blank[i];
        w_sel_sup   = w_sup[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // Lit pattern, bit 6 = segment a down to bit 0 = segment g.
  always_comb begin
    w_seg_lit = 7'b0000000;
    case (w_nib)
      4'h0: w_seg_lit = 7'b1111110;
      4'h1: w_seg_lit = 7'b0110000;
      4'h2: w_seg_lit = 7'b1101101;
      4'h3: w_seg_lit = 7'b1111001;
      4'h4: w_seg_lit = 7'b0110011;
      4'h5: w_seg_lit = 7'b1011011;
      4'h6: w_seg_lit = 7'b1011111;
      4'h7: w_seg_lit = 7'b1110000;
      4'h8: w_seg_lit = 7'b1111111;
      4'h9: w_seg_lit = 7'b1111011;
      4'hA: w_seg_lit = 7'b1110111;
      4'hB: w_seg_lit = 7'b0011111;
      4'hC: w_seg_lit = 7'b1001110;
      4'hD: w_seg_lit = 7'b0111101;
      4'hE: w_seg_lit = 7'b1001111;
      4'hF: w_seg_lit = 7'b1000111;
      default: w_seg_lit = 7'b0000000;
    endcase
  end

  // A suppressed digit with a decimal point keeps its anode for the dp alone.
  assign w_an_on  = (r_pre >= c_GUARD) && !w_sel_blank && (!w_sel_sup || w_sel_dp);
  assign w_seg_on = w_an_on && !w_sel_sup;
  assign w_dp_on  = w_an_on && w_sel_dp;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pre        <= '0;
      r_idx        <= '0;
      r_pending    <= 1'b0;
      r_sh_data    <= '0;
      r_sh_dp      <= '0;
      r_sh_blank   <= '0;
      r_dsp_data   <= '0;
      r_dsp_dp     <= '0;
      r_dsp_blank  <= '0;
      r_seg        <= {7{c_INV}};
      r_dp         <= c_INV;
      r_an         <= {DIGITS{c_INV}};
      r_frame_done <= 1'b0;
    end else begin
      r_pre        <= r_pre + 1'b1;
      r_frame_done <= w_bound;
      if (w_tick) begin
        r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
      end

      if (load) begin
        r_sh_data  <= data;
        r_sh_dp    <= dp_in;
        r_sh_blank <= blank;
      end

      if (w_bound && load) begin
        r_dsp_data  <= data;
        r_dsp_dp    <= dp_in;
        r_dsp_blank <= blank;
        r_pending   <= 1'b0;
      end else if (w_bound && r_pending) begin
        r_dsp_data  <= r_sh_data;
        r_dsp_dp    <= r_sh_dp;
        r_dsp_blank <= r_sh_blank;
        r_pending   <= 1'b0;
      end else if (load) begin
        r_pending   <= 1'b1;
      end

      r_seg <= (w_seg_on ? w_seg_lit : 7'b0000000) ^ {7{c_INV}};
      r_dp  <= w_dp_on ^ c_INV;
      r_an  <= (w_an_on ? w_onehot : {DIGITS{1'b0}}) ^ {DIGITS{c_INV}};
    end
  end

  assign a          = r_seg[6];
  assign b          = r_seg[5];
  assign c          = r_seg[4];
  assign d          = r_seg[3];
  assign e          = r_seg[2];
  assign f          = r_seg[1];
  assign g          = r_seg[0];
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire
